// File: rtl/readout_pkg.sv
// Shared types and default sizing for the readout arbiter family.
//   state_t      : sequencer state encoding
//   DEF_*        : default parameter values used by the arbiter blocks
package readout_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker: rotates req_valid so that rr_ptr has the
// highest priority, then returns the first set requester.
//   req_valid : per-requester valid bits
//   rr_ptr    : index holding highest priority this cycle
//   grant     : selected requester index (0 when none valid)
//   any_valid : at least one requester is valid
module rr_priority_pick
    import readout_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    grant,
    output logic               any_valid
);

    logic [ID_W-1:0] idx;

    // NUM_REQ is a power of two, so the ID_W-bit add wraps modulo NUM_REQ.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + ID_W'(k);
            if (!any_valid && req_valid[idx]) begin
                grant     = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/readout_arbiter.sv
// Round-robin arbiter and sequencer for the shared wrap-around adder.
// One requester is granted at a time; its operands are latched, summed
// modulo 2^WIDTH and presented with the requester id on a valid/ready port.
//   clk, rst        : clock, synchronous active-high reset
//   ena             : blocks new grants when low
//   req_valid/a/b   : per-requester request and packed operands
//   req_ready       : one-hot accept strobe (combinational from IDLE state)
//   out_valid/data/id, out_ready : result port
//   busy            : sequencer not in IDLE
//   done_count      : completed transfers, wrapping
module readout_arbiter
    import readout_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]          out_id,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [CNT_W-1:0]         done_count
);

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] op_id;
    logic            any_valid;
    logic            take;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] sum;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

    assign sel_a = req_a[grant*WIDTH +: WIDTH];
    assign sel_b = req_b[grant*WIDTH +: WIDTH];

    // Carry is dropped: WIDTH-bit result wraps.
    assign sum = op_a + op_b;

    // Next-state and the combinational accept strobe.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && ena && any_valid) begin
                    take             = 1'b1;
                    req_ready[grant] = 1'b1;
                    state_next       = COMPUTE;
                end
            end
            COMPUTE: state_next = OUTPUT;
            OUTPUT: begin
                // out_valid is always high in OUTPUT
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, operand, result and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            rr_ptr     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= '0;
            done_count <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            if (take) begin
                op_a  <= sel_a;
                op_b  <= sel_b;
                op_id <= grant;
            end
            if (state == COMPUTE) begin
                out_data  <= sum;
                out_id    <= op_id;
                out_valid <= 1'b1;
            end
            if (state == OUTPUT && out_ready) begin
                out_valid  <= 1'b0;
                // Just-served requester drops to lowest priority.
                rr_ptr     <= op_id + ID_W'(1);
                done_count <= done_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_readout_arbiter.sv
// Directed self-checking bench for readout_arbiter with a result scoreboard.
module tb_readout_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    logic                     clk;
    logic                     rst;
    logic                     ena;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [ID_W-1:0]          out_id;
    logic                     out_ready;
    logic                     busy;
    logic [CNT_W-1:0]         done_count;

    readout_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .busy       (busy),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    req_t              pend_q[$];
    logic [ID_W-1:0]   gnt_q[$];
    logic [ID_W+WIDTH-1:0] out_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue a request; callers add them in the order they expect service.
    task automatic add_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_t r;
        logic [WIDTH-1:0] s;
        r.id = ID_W'(id);
        r.a  = a;
        r.b  = b;
        s    = a + b;
        pend_q.push_back(r);
        gnt_q.push_back(ID_W'(id));
        out_q.push_back({ID_W'(id), s});
    endtask

    // Each requester presents its oldest pending request.
    task automatic present();
        logic [NUM_REQ-1:0]       v;
        logic [NUM_REQ*WIDTH-1:0] a;
        logic [NUM_REQ*WIDTH-1:0] b;
        v = '0;
        a = '0;
        b = '0;
        foreach (pend_q[k]) begin
            if (!v[pend_q[k].id]) begin
                v[pend_q[k].id] = 1'b1;
                a[pend_q[k].id*WIDTH +: WIDTH] = pend_q[k].a;
                b[pend_q[k].id*WIDTH +: WIDTH] = pend_q[k].b;
            end
        end
        req_valid = v;
        req_a     = a;
        req_b     = b;
    endtask

    // One clock: observe at negedge, then update requesters after the edge.
    task automatic cycle();
        int gid;
        logic [ID_W-1:0] eg;
        logic [ID_W+WIDTH-1:0] eo;
        gid = -1;
        @(negedge clk);
        if (req_ready != '0) begin
            chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            chk("ready_has_valid", 32'(req_ready & ~req_valid), 32'd0);
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (req_ready[i]) gid = i;
            end
            if (gnt_q.size() == 0) begin
                chk("unexpected_grant", 32'(req_ready), 32'd0);
            end else begin
                eg = gnt_q.pop_front();
                chk("grant", 32'(req_ready), 32'(1) << eg);
            end
        end
        if (out_valid && out_ready) begin
            if (out_q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                eo = out_q.pop_front();
                chk("out_id", 32'(out_id), 32'(eo[ID_W+WIDTH-1:WIDTH]));
                chk("out_data", 32'(out_data), 32'(eo[WIDTH-1:0]));
            end
        end
        @(posedge clk);
        #1;
        if (gid >= 0) begin
            for (int k = 0; k < pend_q.size(); k++) begin
                if (int'(pend_q[k].id) == gid) begin
                    pend_q.delete(k);
                    break;
                end
            end
        end
        present();
    endtask

    task automatic drain(input int budget, output int used);
        used = 0;
        while (out_q.size() != 0 && used < budget) begin
            cycle();
            used++;
        end
        chk("drain_in_budget", 32'(out_q.size()), 32'd0);
    endtask

    int n;

    initial begin
        rst       = 1'b1;
        ena       = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'hF;
        req_a     = 32'h11223344;
        req_b     = 32'h55667788;

        // Reset state, with requests pending while rst is high
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_done_count", 32'(done_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = '0;
        rst       = 1'b0;
        @(posedge clk);
        #1;

        // Single request: 1 + 2
        add_req(0, 8'h01, 8'h02);
        present();
        #1;
        chk("single_ready", 32'(req_ready), 32'b0001);
        cycle();
        chk("single_compute_busy", 32'(busy), 32'd1);
        chk("single_compute_ready", 32'(req_ready), 32'd0);
        chk("single_compute_valid", 32'(out_valid), 32'd0);
        cycle();
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_out_data", 32'(out_data), 32'h03);
        chk("single_out_id", 32'(out_id), 32'd0);
        cycle();
        chk("single_done_valid", 32'(out_valid), 32'd0);
        chk("single_done_count", 32'(done_count), 32'd1);
        chk("single_done_busy", 32'(busy), 32'd0);

        // Wrap arithmetic; pointer is 1 so requester 1 goes first
        add_req(1, 8'hFF, 8'h00);
        add_req(2, 8'hFF, 8'hFF);
        present();
        drain(40, n);
        chk("wrap_done_count", 32'(done_count), 32'd3);

        // Serve requester 3 so the pointer returns to 0
        add_req(3, 8'h10, 8'h20);
        present();
        drain(40, n);

        // Round robin with all four valid, requester 0 re-requesting
        add_req(0, 8'h80, 8'h80);
        add_req(1, 8'h12, 8'h34);
        add_req(2, 8'hA5, 8'h5A);
        add_req(3, 8'hC3, 8'h4D);
        add_req(0, 8'h7F, 8'h01);
        present();
        drain(60, n);
        chk("rr_cycles", 32'(n), 32'd15);
        chk("rr_done_count", 32'(done_count), 32'd9);

        // Backpressure in OUTPUT, with a newcomer arriving meanwhile
        out_ready = 1'b0;
        add_req(1, 8'h5A, 8'h33);
        present();
        cycle();
        cycle();
        add_req(2, 8'h01, 8'h01);
        present();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h8D);
            chk("bp_id", 32'(out_id), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        chk("bp_done_count", 32'(done_count), 32'd9);
        out_ready = 1'b1;
        cycle();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_count", 32'(done_count), 32'd10);
        drain(40, n);
        chk("bp_next_count", 32'(done_count), 32'd11);

        // ena low blocks grants in IDLE
        ena = 1'b0;
        add_req(0, 8'h07, 8'h08);
        present();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("ena_ready", 32'(req_ready), 32'd0);
            chk("ena_busy", 32'(busy), 32'd0);
        end
        ena = 1'b1;
        cycle();
        // Drop ena mid-COMPUTE; this transfer must still finish
        ena = 1'b0;
        add_req(1, 8'h01, 8'h01);
        present();
        cycle();
        chk("ena_out_valid", 32'(out_valid), 32'd1);
        chk("ena_out_data", 32'(out_data), 32'h0F);
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("ena_no_grant", 32'(req_ready), 32'd0);
            chk("ena_idle_busy", 32'(busy), 32'd0);
        end
        chk("ena_done_count", 32'(done_count), 32'd12);
        ena = 1'b1;
        drain(40, n);
        chk("ena_resume_count", 32'(done_count), 32'd13);

        // Reset while a result is waiting in OUTPUT
        out_ready = 1'b0;
        add_req(3, 8'h40, 8'h40);
        present();
        cycle();
        cycle();
        chk("mid_rst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        cycle();
        void'(out_q.pop_back());
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_id", 32'(out_id), 32'd0);
        chk("mid_rst_count", 32'(done_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        // Pointer was 2 before reset; after reset requester 0 must win
        add_req(0, 8'h21, 8'h21);
        add_req(2, 8'h30, 8'h03);
        present();
        drain(40, n);
        chk("post_rst_count", 32'(done_count), 32'd2);

        chk("grants_consumed", 32'(gnt_q.size()), 32'd0);
        chk("requests_consumed", 32'(pend_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/readout_arbiter.md
Name: readout_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 8-bit wrap-around adder/readout datapath.
  - The datapath computes out = a + b mod 2^WIDTH, e.g. 0x01+0x02=0x03, 0xFF+0xFF=0xFE.
- Up to NUM_REQ requesters each present an operand pair with valid/ready.
- The block grants one requester at a time, runs the add, and presents the result with the requester ID on a valid/ready output port.
- Sits between the pin-level input muxing and the fast readout bus inside the tile top.

Parameters:
- NUM_REQ, 4, number of requesters (power of two, 2..8).
- WIDTH, 8, operand/result width.
- ID_W, $clog2(NUM_REQ), width of requester ID.
- CNT_W, 16, width of completed-transaction counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  global enable; low blocks new grants only.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- out_valid  out  1  result valid.
- out_data  out  WIDTH  sum mod 2^WIDTH.
- out_id  out  ID_W  index of requester that produced out_data.
- out_ready  in  1  downstream accept.
- busy  out  1  high whenever state != IDLE.
- done_count  out  CNT_W  completed transfers, wraps at 2^CNT_W.

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_id=0, done_count=0, operand regs=0.
  - req_ready=0 while rst is high.
  - Reset mid-transaction discards the in-flight operation without completing it; done_count is not incremented.
- States: IDLE, COMPUTE, OUTPUT.
- IDLE:
  - Grant is combinational: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready[grant]=1 only if ena=1 and some req_valid is set; all other req_ready bits are 0.
  - On the handshake edge: capture a, b and id=grant into registers, then go to COMPUTE.
  - With no valid request or ena=0: stay in IDLE, req_ready=0.
- COMPUTE:
  - out_data <= (a+b)[WIDTH-1:0] (carry dropped); out_id <= id; out_valid <= 1; go to OUTPUT.
  - req_ready=0.
- OUTPUT:
  - Hold out_valid, out_data and out_id stable until out_valid & out_ready.
  - On that edge: out_valid <= 0, rr_ptr <= id+1 mod NUM_REQ, done_count <= done_count+1, go to IDLE.
  - req_ready=0 throughout.
- Latency: handshake at edge t gives out_valid=1 after edge t+1. Minimum per-transaction period is 3 cycles with out_ready held high.
- Requester rules: once req_valid is asserted, req_valid/req_a/req_b must stay stable until req_ready. The arbiter never revokes a grant within a cycle.
- ena=0 in COMPUTE/OUTPUT: the in-flight transaction completes normally; only IDLE grants are blocked.
- Fairness: a requester that was just served has lowest priority next. With all NUM_REQ requesters continuously valid, grants cycle 0,1,2,3,0,…
- out_ready=1 before out_valid has no effect.
- A simultaneous new req_valid during OUTPUT is ignored until IDLE.
- done_count wraps 0xFFFF→0x0000 with no saturation.

Decomposition:
- Shared package readout_pkg:
  - state enum (IDLE=2'd0, COMPUTE=2'd1, OUTPUT=2'd2).
  - default WIDTH and NUM_REQ constants.
- One sub-module, rr_priority_pick:
  - Combinational rotate-and-priority-encode of req_valid by rr_ptr.
  - Outputs grant index and any_valid.
  - Reusable by other tile arbiters.
- Adder and FSM stay in readout_arbiter.

Test Plan:
- Reset then single request: req_valid=0001, a=0x01, b=0x02 → req_ready=0001 for one cycle; out_valid two edges later; out_data=0x03, out_id=0; done_count=1.
- Wrap arithmetic: requester 2 with a=0xFF, b=0xFF → out_data=0xFE, out_id=2. Requester 1 with a=0xFF, b=0x00 → out_data=0xFF.
- Round-robin: all four valid with out_ready=1 → out_id sequence 0,1,2,3,0; each req_ready pulse is exactly one cycle and one-hot.
- Backpressure: out_ready=0 for 5 cycles in OUTPUT → out_valid/out_data/out_id stable; no req_ready; on out_ready=1, single completion.
- ena=0: requests pending in IDLE → no req_ready, busy=0. Drop ena mid-COMPUTE → result still delivered, then no further grants.
- Reset mid-OUTPUT: assert rst with out_valid=1 → next cycle out_valid=0, out_data=0, done_count=0, rr_ptr=0; requester 0 is granted first after release.
